// File: rtl/lpddr_subsystem_typedef_pkg.sv
// rtl/lpddr_subsystem_typedef_pkg.sv - shared LPDDR subsystem encodings and hardware low-power FSM states
package lpddr_subsystem_typedef_pkg;

    typedef enum logic [2:0] {
        INIT         = 3'b000,
        NORMAL       = 3'b001,
        POWER_DOWN   = 3'b010,
        SELF_REFRESH = 3'b011
    } lpddr_op_mode_e;

    typedef enum logic [1:0] {
        NOT_SELFREF   = 2'b00,
        PHY_SELFREF   = 2'b01,
        OTHER_SELFREF = 2'b10,
        AUTO_SELFREF  = 2'b11
    } selfref_type_e;

    typedef enum logic [2:0] {
        WAIT_INIT,
        RUN,
        REQ,
        LP,
        DENY,
        EXIT
    } hwlp_state_e;

    function automatic lpddr_op_mode_e op_mode_of(hwlp_state_e s);
        case (s)
            WAIT_INIT: return INIT;
            LP:        return SELF_REFRESH;
            default:   return NORMAL;
        endcase
    endfunction

endpackage

// File: rtl/lpddr_hwlp_requester_timer.sv
// rtl/lpddr_hwlp_requester_timer.sv - clear/enable saturating cycle counter with equality compare
module lpddr_hwlp_timer #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_cmp,
    output logic         o_hit
);

    logic [W-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            cnt <= '0;
        end else if (i_en && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign o_hit = (cnt == i_cmp);

endmodule

// File: rtl/lpddr_hwlp_requester.sv
// rtl/lpddr_hwlp_requester.sv - csysreq/csysack/cactive low-power handshake initiator with idle and software entry
module lpddr_hwlp_requester
    import lpddr_subsystem_typedef_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_idle_cycles,
    input  logic             i_sw_sr_req,
    input  logic             i_wake,
    input  logic             i_csysack,
    input  logic             i_cactive,
    output logic             o_csysreq,
    output logic [2:0]       o_op_mode,
    output logic [1:0]       o_sr_type,
    output logic             o_lp_active,
    output logic             o_deny_pulse,
    output logic             o_timeout_err,
    output logic [15:0]      o_entry_cnt
);

    localparam int              TO_W   = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_CMP = TO_W'(ACK_TIMEOUT - 1);

    hwlp_state_e      state, state_nxt;
    logic             sw_armed, sw_mode;
    logic             idle_now, idle_hit, auto_go, sw_go, lp_exit;
    logic             to_hit, to_err, to_clr;
    logic [CNT_W-1:0] idle_cmp;

    assign idle_now = i_enable && !i_cactive && !i_wake;
    assign idle_cmp = i_idle_cycles - CNT_W'(1);
    assign auto_go  = idle_now && (i_idle_cycles != '0) && idle_hit;
    assign sw_go    = i_sw_sr_req && sw_armed;
    assign lp_exit  = i_wake || i_cactive || (!sw_mode && !i_enable) || (sw_mode && !i_sw_sr_req);
    assign to_clr   = (state_nxt != state) || !((state == REQ) || (state == EXIT));
    // An ack arriving on the expiry cycle takes precedence over the timeout
    assign to_err   = to_hit && (((state == REQ) && i_csysack) || ((state == EXIT) && !i_csysack));

    lpddr_hwlp_timer #(.W(CNT_W)) u_idle_timer (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr ((state != RUN) || !idle_now),
        .i_en  (idle_now),
        .i_cmp (idle_cmp),
        .o_hit (idle_hit)
    );

    lpddr_hwlp_timer #(.W(TO_W)) u_ack_timer (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (to_clr),
        .i_en  (1'b1),
        .i_cmp (TO_CMP),
        .o_hit (to_hit)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_INIT: if (i_csysack) state_nxt = RUN;
            RUN:       if (sw_go || auto_go) state_nxt = REQ;
            REQ: begin
                if (!i_csysack) begin
                    state_nxt = i_cactive ? DENY : LP;
                end else if (to_hit) begin
                    state_nxt = EXIT;
                end
            end
            LP:        if (lp_exit) state_nxt = EXIT;
            DENY:      state_nxt = EXIT;
            EXIT:      if (i_csysack) state_nxt = RUN;
            default:   state_nxt = WAIT_INIT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= WAIT_INIT;
            sw_armed      <= 1'b1;
            sw_mode       <= 1'b0;
            o_csysreq     <= 1'b1;
            o_op_mode     <= INIT;
            o_sr_type     <= NOT_SELFREF;
            o_lp_active   <= 1'b0;
            o_deny_pulse  <= 1'b0;
            o_timeout_err <= 1'b0;
            o_entry_cnt   <= 16'd0;
        end else begin
            state <= state_nxt;
            // A consumed sw request stays locked out until the level drops
            if ((state == RUN) && sw_go) begin
                sw_armed <= 1'b0;
                sw_mode  <= 1'b1;
            end else begin
                if (!i_sw_sr_req) sw_armed <= 1'b1;
                if ((state == RUN) && auto_go) sw_mode <= 1'b0;
            end
            if ((state == REQ) && (state_nxt == LP)) o_entry_cnt <= o_entry_cnt + 16'd1;
            if (to_err) o_timeout_err <= 1'b1;
            o_csysreq    <= !((state == REQ) || (state == LP));
            o_op_mode    <= op_mode_of(state);
            o_sr_type    <= (state == LP) ? OTHER_SELFREF : NOT_SELFREF;
            o_lp_active  <= (state == LP);
            o_deny_pulse <= (state == DENY);
        end
    end

endmodule
